// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage.
// Holds the condition-code enum and the flag / flag-write bit positions.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: Cond field vs registered {N,Z,C,V}.
// Ports: Cond (4), Flags (4) in; CondEx out. NV (reserved) never passes.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n;
  logic z;
  logic c;
  logic v;
  logic ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    unique case (cond_e'(Cond))
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = ge;
      LT: CondEx = ~ge;
      GT: CondEx = ~z & ge;
      LE: CondEx = z | ~ge;
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Flags register (NZ / CV groups) and condition-gated write enables.
// In: clk, reset, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall.
// Out: PCSrc, RegWrite, MemWrite, CondEx, Flags (registered {N,Z,C,V}).
module cond_logic
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] nz;
  logic [1:0] cv;
  logic       upd;

  assign Flags = {nz, cv};

  // CondEx sees the pre-edge flags, so a flag-setting
  // instruction is qualified by the old values.
  cond_check u_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  assign upd = ~Stall & CondEx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz <= 2'b00;
    end else if (upd & FlagW[FLAGW_NZ]) begin
      nz <= ALUFlags[FLAG_N:FLAG_Z];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cv <= 2'b00;
    end else if (upd & FlagW[FLAGW_CV]) begin
      cv <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vectors, a flag model,
// and a negedge compare process plus hand-computed literal checks.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Stall;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  int checks = 0;
  int failures = 0;

  logic [3:0] m = 4'b0000;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .Stall    (Stall),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  always #5 clk = ~clk;

  // Pairs of conditions share a base test; odd codes invert it.
  function automatic logic pass(input logic [3:0] c,
                                input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    b = z;
      3'd1:    b = cy;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = cy & ~z;
      3'd5:    b = (n == v);
      3'd6:    b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m = 4'b0000;
    end else if (!Stall && pass(Cond, m)) begin
      if (FlagW[1]) m[3:2] = ALUFlags[3:2];
      if (FlagW[0]) m[1:0] = ALUFlags[1:0];
    end
  end

  task automatic chk(input string name,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic ce;
    ce = pass(Cond, m);
    chk("flags", Flags, m);
    chk("condex", {3'b0, CondEx}, {3'b0, ce});
    chk("pcsrc", {3'b0, PCSrc}, {3'b0, PCS & ce});
    chk("regwrite", {3'b0, RegWrite}, {3'b0, RegW & ce & ~NoWrite});
    chk("memwrite", {3'b0, MemWrite}, {3'b0, MemW & ce});
  end

  task automatic drive(input logic [3:0] c, input logic [3:0] a,
                       input logic [1:0] fw, input logic p,
                       input logic r, input logic mw,
                       input logic nw, input logic st);
    @(posedge clk);
    #1;
    Cond = c; ALUFlags = a; FlagW = fw;
    PCS = p; RegW = r; MemW = mw; NoWrite = nw; Stall = st;
  endtask

  initial begin
    Cond = 4'b0001; ALUFlags = 4'b1111; FlagW = 2'b11;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    NoWrite = 1'b0; Stall = 1'b0;
    #1 reset = 1'b1;

    // reset holds flags at zero despite writes requested
    drive(4'b0001, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
    drive(4'b0001, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
    #1;
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_ne", {3'b0, CondEx}, 4'b0001);
    drive(4'b1111, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
    #1;
    chk("rst_nv", {3'b0, CondEx}, 4'b0000);
    chk("rst_nv_wr", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    drive(4'b0000, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
    #1;
    chk("rst_eq", {3'b0, CondEx}, 4'b0000);
    @(posedge clk);
    #3 reset = 1'b0;

    // group enables
    drive(4'b1110, 4'b1010, 2'b10, 0, 0, 0, 0, 0);
    drive(4'b1110, 4'b0101, 2'b01, 0, 0, 0, 0, 0);
    #1 chk("grp_nz", Flags, 4'b1000);
    drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    #1 chk("grp_cv", Flags, 4'b1001);

    // stall holds flags
    drive(4'b1110, 4'b0110, 2'b11, 1, 1, 1, 0, 1);
    #1 chk("stall_wr", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0111);
    drive(4'b1110, 4'b0110, 2'b11, 0, 0, 0, 0, 1);
    #1 chk("stall_hold", Flags, 4'b1001);

    // async reset pulse between edges
    #2 reset = 1'b1;
    #1 chk("async_rst", Flags, 4'b0000);
    reset = 1'b0;

    // failed condition: no writes, no flag update
    drive(4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
    #1;
    chk("fail_ce", {3'b0, CondEx}, 4'b0000);
    chk("fail_wr", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    #1 chk("fail_flags", Flags, 4'b0000);

    // compare-class: flags set, register write suppressed
    drive(4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1, 0);
    #1 chk("nowr_rw", {3'b0, RegWrite}, 4'b0000);
    drive(4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
    #1;
    chk("nowr_flags", Flags, 4'b0110);
    // EQ sees old Z=1, passes, and clears flags
    chk("rbw_ce", {3'b0, CondEx}, 4'b0001);
    drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    #1 chk("rbw_flags", Flags, 4'b0000);

    // condition sweep over all flag values and codes
    for (int f = 0; f < 16; f++) begin
      drive(4'b1110, 4'(f), 2'b11, 0, 0, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
        drive(4'(c), 4'(15 - f), 2'b00, 1, 1, 1, 0, 0);
        #1;
        if (f == 2 && c == 8)
          chk("hi_lit", {3'b0, CondEx}, 4'b0001);
        if (f == 6 && c == 9)
          chk("ls_lit", {3'b0, CondEx}, 4'b0001);
        if (f == 9 && c == 10)
          chk("ge_lit", {3'b0, CondEx}, 4'b0001);
        if (f == 8 && c == 12)
          chk("gt_lit", {3'b0, CondEx}, 4'b0000);
      end
    end

    drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution and flag-register stage directly downstream of the ALU in the single-cycle ARM-subset datapath. Latches the ALU's N, Z, C, V flags into an architectural flags register under per-group write enables and evaluates the instruction's 4-bit condition field against the registered flags. Gates the decoder's PC-write, register-write and memory-write requests so that failed-condition instructions have no architectural effect. Has no data-path width; 32-bit agnostic.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears flags register
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU for the current instruction
- FlagW  in  2  decoder flag-write request: [1] updates N,Z; [0] updates C,V
- PCS  in  1  decoder request to write PC
- RegW  in  1  decoder request to write register file
- MemW  in  1  decoder request to write data memory
- NoWrite  in  1  compare-class op (CMP/CMN/TST): suppress RegWrite regardless of condition
- Stall  in  1  hold: no flag update this cycle
- PCSrc  out  1  PCS & CondEx
- RegWrite  out  1  RegW & CondEx & ~NoWrite
- MemWrite  out  1  MemW & CondEx
- CondEx  out  1  condition passed, evaluated against registered flags
- Flags  out  4  registered {N,Z,C,V}

## Operation
- Flags register split into two 2-bit groups: NZ = Flags[3:2], CV = Flags[1:0].
- On rising clk, if ~reset & ~Stall & CondEx: FlagW[1] loads NZ <= ALUFlags[3:2]; FlagW[0] loads CV <= ALUFlags[1:0]. Groups independent; unselected group holds.
- Failed condition (CondEx=0) never updates flags, even with FlagW set.
- CondEx is combinational from Cond and registered Flags only (never from ALUFlags of the same instruction).
- Condition table: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved -> CondEx=0.
- C convention: ALU delivers C=1 after SUB when no borrow (A >= B unsigned); HI/LS/CS/CC rely on this.
- Stall does not mask PCSrc/RegWrite/MemWrite; the datapath's own write enables are gated by Stall upstream.
- All outputs are combinational functions of inputs and Flags; no X propagation from unused inputs when CondEx=0.

## Timing
- Reset: Flags=4'b0000 asynchronously on reset assertion; outputs then follow combinationally (e.g. Cond=EQ -> CondEx=0, Cond=NE -> CondEx=1, AL -> 1).
- Reset deasserted mid-cycle: first flag update on the first rising clk with reset low.
- Flag latency: flags written at edge k are visible to CondEx of the instruction in cycle k+1.
- Output latency: zero cycles (combinational) from Cond/PCS/RegW/MemW/NoWrite to gated outputs.
- Simultaneous FlagW=2'b11 and passing condition: all four flags update same edge.
- Stall=1 with FlagW set: flags hold; instruction re-presented next cycle evaluates against unchanged flags.
- Flag-setting instruction whose own condition depends on flags: uses pre-update values (read-before-write within the edge).

## Structure
- Package cond_pkg: enum cond_e (EQ..AL, NV=4'b1111), flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, FLAGW_NZ=1, FLAGW_CV=0.
- Sub-module cond_check: purely combinational (Cond, Flags) -> CondEx; instantiated once. cond_logic holds the two 2-bit flag registers and output gating.

## Test plan
- Reset: assert reset with ALUFlags=4'b1111, FlagW=2'b11 -> Flags=0000 throughout; Cond=0001 (NE) -> CondEx=1; Cond=1111 -> CondEx=0, PCSrc=RegWrite=MemWrite=0 with PCS=RegW=MemW=1.
- Group enables: Cond=AL, ALUFlags=1010, FlagW=2'b10, one edge -> Flags=1000; then ALUFlags=0101, FlagW=2'b01 -> Flags=1001.
- Condition sweep: for each Flags in 0000..1111 (loaded via AL+FlagW=11), all 16 Cond values -> CondEx matches table (256 checks); e.g. Flags=0010, Cond=1000 (HI) -> 1; Flags=0110, Cond=1001 (LS) -> 1.
- Failed condition: Flags=0000, Cond=EQ, FlagW=11, ALUFlags=1111, PCS=RegW=MemW=1 -> CondEx=0, all writes 0, Flags stays 0000 after edge.
- NoWrite: Cond=AL, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 -> RegWrite=0, Flags=0110 next cycle.
- Stall and async reset mid-run: Flags=1001, Stall=1, AL, FlagW=11, ALUFlags=0110 -> Flags holds 1001; pulse reset between edges -> Flags=0000 immediately, before next clk.
